// File: rtl/safe_pkg.sv
// Shared constants for the safe code checker: keypad codes, FSM encoding
// and the timer width helper.
package safe_pkg;

   localparam logic [3:0] KEY_HASH = 4'd10;
   localparam logic [3:0] KEY_STAR = 4'd11;
   localparam logic [3:0] KEY_NONE = 4'd13;

   typedef enum logic [2:0] {
      S_LOCKED  = 3'd0,
      S_CHECK   = 3'd1,
      S_OPEN    = 3'd2,
      S_PROGRAM = 3'd3,
      S_LOCKOUT = 3'd4
   } state_t;

   function automatic int unsigned tmr_width(input int unsigned a, input int unsigned b);
      return $clog2((a > b) ? a : b) + 1;
   endfunction

endpackage

// File: rtl/safe_timer.sv
// Loadable saturating down-counter shared by the open and lockout timeouts.
// expired marks the cycle on whose closing edge the count reaches zero.
module safe_timer #(
   parameter int unsigned W = 14
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expired
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   // A value of 1 or 0 means the timeout ends on this edge, so a load of N
   // keeps the owning state alive for exactly N cycles.
   assign expired = (cnt[W-1:1] == '0);

endmodule

// File: rtl/safe_code_checker.sv
// PIN entry, compare, re-lock timeout and code programming for the keypad safe.
// Define SAFE_LOCKOUT_EN to enable the failed-attempt counter and LOCKOUT state.
module safe_code_checker
   import safe_pkg::*;
#(
   parameter int unsigned            CODE_LEN       = 4,
   parameter logic [CODE_LEN*4-1:0]  DEFAULT_CODE   = 16'h1234,
   parameter int unsigned            UNLOCK_CYCLES  = 1000,
   parameter int unsigned            MAX_FAILS      = 3,
   parameter int unsigned            LOCKOUT_CYCLES = 5000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] key_code,
   output logic       unlocked,
   output logic       lockout,
   output logic       ok_pulse,
   output logic       err_pulse,
   output logic [3:0] digit_cnt,
   output logic [2:0] state
);

   localparam int unsigned BW   = CODE_LEN * 4;
   localparam int unsigned TW   = tmr_width(UNLOCK_CYCLES, LOCKOUT_CYCLES);
   localparam logic [3:0]  FULL = 4'(CODE_LEN);

   state_t          st;
   logic [BW-1:0]   code, entry, entry_dig;
   logic [3:0]      cnt, cnt_dig;
   logic            ovf, ovf_dig;
   logic            is_digit, is_key, full_ok, match, lock_hit;
   logic            tmr_load, tmr_exp;
   logic [TW-1:0]   tmr_val;

   assign is_digit  = (key_code <= 4'd9);
   assign is_key    = is_digit || (key_code == KEY_HASH) || (key_code == KEY_STAR);
   assign full_ok   = (cnt == FULL) && !ovf;
   assign match     = full_ok && (entry == code);
   assign digit_cnt = cnt;
   assign state     = st;

`ifdef SAFE_LOCKOUT_EN
   localparam int unsigned FW = $clog2(MAX_FAILS + 1);
   logic [FW-1:0] fails, fails_inc;

   assign fails_inc = (fails == FW'(MAX_FAILS)) ? fails : fails + 1'b1;
   assign lock_hit  = (fails_inc == FW'(MAX_FAILS));
`else
   assign lock_hit  = 1'b0;
   assign lockout   = 1'b0;
`endif

   // Next entry-buffer contents if the current key is a digit.
   always_comb begin
      entry_dig = entry;
      cnt_dig   = cnt;
      ovf_dig   = ovf;
      if (cnt == FULL) begin
         ovf_dig = 1'b1;
      end else begin
         entry_dig = (entry << 4) | BW'(key_code);
         cnt_dig   = cnt + 4'd1;
      end
   end

   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = TW'(UNLOCK_CYCLES);
      unique case (st)
         S_CHECK: begin
            tmr_load = match || lock_hit;
            if (!match) tmr_val = TW'(LOCKOUT_CYCLES);
         end
         S_OPEN:    tmr_load = !tmr_exp && (key_code == KEY_STAR);
         S_PROGRAM: tmr_load = !tmr_exp && is_key;
         default:   tmr_load = 1'b0;
      endcase
   end

   safe_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .expired  (tmr_exp)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st        <= S_LOCKED;
         code      <= DEFAULT_CODE;
         entry     <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         unlocked  <= 1'b0;
         ok_pulse  <= 1'b0;
         err_pulse <= 1'b0;
`ifdef SAFE_LOCKOUT_EN
         lockout   <= 1'b0;
         fails     <= '0;
`endif
      end else begin
         ok_pulse  <= 1'b0;
         err_pulse <= 1'b0;
         unique case (st)
            S_LOCKED: begin
               if (is_digit) begin
                  entry <= entry_dig;
                  cnt   <= cnt_dig;
                  ovf   <= ovf_dig;
               end else if (key_code == KEY_STAR) begin
                  entry <= '0;
                  cnt   <= '0;
                  ovf   <= 1'b0;
               end else if (key_code == KEY_HASH) begin
                  st <= S_CHECK;
               end
            end
            S_CHECK: begin
               entry <= '0;
               cnt   <= '0;
               ovf   <= 1'b0;
               if (match) begin
                  ok_pulse <= 1'b1;
                  unlocked <= 1'b1;
                  st       <= S_OPEN;
`ifdef SAFE_LOCKOUT_EN
                  fails    <= '0;
`endif
               end else begin
                  err_pulse <= 1'b1;
`ifdef SAFE_LOCKOUT_EN
                  fails     <= fails_inc;
                  if (lock_hit) begin
                     st      <= S_LOCKOUT;
                     lockout <= 1'b1;
                  end else begin
                     st <= S_LOCKED;
                  end
`else
                  st        <= S_LOCKED;
`endif
               end
            end
            S_OPEN: begin
               if (tmr_exp || key_code == KEY_HASH) begin
                  st       <= S_LOCKED;
                  unlocked <= 1'b0;
               end else if (key_code == KEY_STAR) begin
                  st    <= S_PROGRAM;
                  entry <= '0;
                  cnt   <= '0;
                  ovf   <= 1'b0;
               end
            end
            S_PROGRAM: begin
               // Expiry is checked first so a key on the expiry edge is dropped.
               if (tmr_exp) begin
                  st       <= S_LOCKED;
                  unlocked <= 1'b0;
                  entry    <= '0;
                  cnt      <= '0;
                  ovf      <= 1'b0;
               end else if (is_digit) begin
                  entry <= entry_dig;
                  cnt   <= cnt_dig;
                  ovf   <= ovf_dig;
               end else if (key_code == KEY_HASH || key_code == KEY_STAR) begin
                  if (key_code == KEY_HASH) begin
                     if (full_ok) begin
                        code     <= entry;
                        ok_pulse <= 1'b1;
                     end else begin
                        err_pulse <= 1'b1;
                     end
                  end
                  st    <= S_OPEN;
                  entry <= '0;
                  cnt   <= '0;
                  ovf   <= 1'b0;
               end
            end
`ifdef SAFE_LOCKOUT_EN
            S_LOCKOUT: begin
               if (tmr_exp) begin
                  st      <= S_LOCKED;
                  lockout <= 1'b0;
                  fails   <= '0;
               end
            end
`endif
            default: st <= S_LOCKED;
         endcase
      end
   end

endmodule

// File: tb/tb_safe_code_checker.sv
// Randomized bench for safe_code_checker with a queue-based reference model
// and a per-cycle compare process.
module tb_safe_code_checker;
   import safe_pkg::*;

   localparam int unsigned CL  = 4;
   localparam logic [15:0] DEF = 16'h1234;
   localparam int          UNL = 1000;
   localparam int          MF  = 3;
   localparam int          LOC = 5000;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] key_code;
   logic       unlocked, lockout, ok_pulse, err_pulse;
   logic [3:0] digit_cnt;
   logic [2:0] state;

   safe_code_checker #(
      .CODE_LEN       (CL),
      .DEFAULT_CODE   (DEF),
      .UNLOCK_CYCLES  (UNL),
      .MAX_FAILS      (MF),
      .LOCKOUT_CYCLES (LOC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .key_code  (key_code),
      .unlocked  (unlocked),
      .lockout   (lockout),
      .ok_pulse  (ok_pulse),
      .err_pulse (err_pulse),
      .digit_cnt (digit_cnt),
      .state     (state)
   );

   always #5 clk = ~clk;

   int     n_cmp = 0;
   int     n_bad = 0;
   longint tcount = 0;
   bit     chk_en = 1'b0;

   // Reference model: mode numbers follow the published state numbering,
   // entry is a digit queue, timeouts are absolute edge deadlines.
   int     m_mode;
   int     m_q[$];
   bit     m_ovf;
   int     m_fails;
   int     m_code[CL];
   bit     m_ok, m_err;
   longint m_edge = 0;
   longint m_deadline = 0;

   task automatic check(input string name, input longint got, input longint exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   function automatic void m_clear();
      m_q.delete();
      m_ovf = 1'b0;
   endfunction

   function automatic void m_reset();
      m_mode = 0; m_fails = 0; m_ok = 1'b0; m_err = 1'b0;
      m_clear();
      for (int i = 0; i < CL; i++) m_code[i] = int'((DEF >> (4 * (CL - 1 - i))) & 16'hF);
   endfunction

   function automatic void m_digit(input int k);
      if (m_q.size() == CL) m_ovf = 1'b1;
      else m_q.push_back(k);
   endfunction

   function automatic void m_step(input int k);
      bit expd, match;
      m_edge++;
      m_ok = 1'b0; m_err = 1'b0;
      expd = (m_edge >= m_deadline);
      case (m_mode)
         0: begin
            if (k <= 9) m_digit(k);
            else if (k == 11) m_clear();
            else if (k == 10) m_mode = 1;
         end
         1: begin
            match = (m_q.size() == CL) && !m_ovf;
            if (match) for (int i = 0; i < CL; i++) if (m_q[i] != m_code[i]) match = 1'b0;
            m_clear();
            if (match) begin
               m_ok = 1'b1; m_fails = 0; m_mode = 2; m_deadline = m_edge + UNL;
            end else begin
               m_err = 1'b1;
`ifdef SAFE_LOCKOUT_EN
               if (m_fails < MF) m_fails++;
               if (m_fails >= MF) begin m_mode = 4; m_deadline = m_edge + LOC; end
               else m_mode = 0;
`else
               m_mode = 0;
`endif
            end
         end
         2: begin
            if (expd || k == 10) m_mode = 0;
            else if (k == 11) begin m_mode = 3; m_clear(); m_deadline = m_edge + UNL; end
         end
         3: begin
            if (expd) begin
               m_clear(); m_mode = 0;
            end else if (k <= 11) begin
               m_deadline = m_edge + UNL;
               if (k <= 9) m_digit(k);
               else begin
                  if (k == 10) begin
                     if (m_q.size() == CL && !m_ovf) begin
                        for (int i = 0; i < CL; i++) m_code[i] = m_q[i];
                        m_ok = 1'b1;
                     end else m_err = 1'b1;
                  end
                  m_clear(); m_mode = 2;
               end
            end
         end
         4: if (expd) begin m_mode = 0; m_fails = 0; end
         default: m_mode = 0;
      endcase
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) m_reset();
      else m_step(int'(key_code));
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("state",     state,     m_mode);
         check("unlocked",  unlocked,  (m_mode == 2 || m_mode == 3));
         check("lockout",   lockout,   (m_mode == 4));
         check("ok_pulse",  ok_pulse,  m_ok);
         check("err_pulse", err_pulse, m_err);
         check("digit_cnt", digit_cnt, m_q.size());
      end
   end

   task automatic tick(input logic [3:0] k);
      key_code = k;
      @(posedge clk);
      #1;
      tcount++;
   endtask

   task automatic press(input logic [3:0] k);
      tick(k);
      tick(KEY_NONE);
   endtask

   // Digits MSB nibble first, then hash; returns in the hash+2 cycle.
   task automatic send_code(input logic [31:0] d, input int n);
      logic [3:0] nib;
      for (int i = 0; i < n; i++) begin
         nib = d[4 * (n - 1 - i) +: 4];
         press(nib);
      end
      tick(KEY_HASH);
      tick(KEY_NONE);
   endtask

   task automatic summary();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
   endtask

   initial begin
      #3_000_000;
      n_bad++;
      $display("FAIL watchdog: got timeout expected completion");
      summary();
      $finish;
   end

   initial begin
      int n;
      longint t0;
      logic [31:0] d;
      int r;
      key_code = KEY_NONE;
      m_reset();
      repeat (3) @(posedge clk);
      #1;
      chk_en = 1'b1;
      check("rst_state",    state,     0);
      check("rst_unlocked", unlocked,  0);
      check("rst_lockout",  lockout,   0);
      check("rst_digits",   digit_cnt, 0);
      check("rst_ok",       ok_pulse,  0);
      rst = 1'b0;

      // Correct code, exact timing, idle timeout
      press(4'd1); press(4'd2); press(4'd3); press(4'd4);
      check("t1_cnt", digit_cnt, 4);
      tick(KEY_HASH);
      check("t1_check_state", state, 1);
      check("t1_unl_early", unlocked, 0);
      tick(KEY_NONE);
      check("t1_unlocked", unlocked, 1);
      check("t1_ok", ok_pulse, 1);
      n = 1;
      for (int i = 0; i < 2000 && unlocked; i++) begin
         tick(KEY_NONE);
         if (unlocked) n++;
      end
      check("t1_open_len", n, UNL);
      check("t1_relocked", state, 0);

      // Three wrong attempts
      for (int a = 0; a < 3; a++) begin
         send_code(32'h1235, 4);
         check("t2_err", err_pulse, 1);
      end
`ifdef SAFE_LOCKOUT_EN
      t0 = tcount;
      check("t2_lockout", lockout, 1);
      check("t2_state", state, 4);
      send_code(32'h1234, 4);
      check("t2_locked_out", unlocked, 0);
      for (int i = 0; i < 6000 && state != 3'd0; i++) tick(KEY_NONE);
      check("t2_lock_len", tcount - t0, LOC);
`else
      t0 = tcount;
      check("t2_no_lockout", lockout, 0);
      check("t2_state", state, 0);
`endif

      // Overflowing entry
      send_code(32'h12345, 5);
      check("t3_err", err_pulse, 1);
      check("t3_unlocked", unlocked, 0);
      check("t3_cnt", digit_cnt, 0);

      // Star cancels a partial entry
      press(4'd1); press(4'd2);
      check("t5_cnt", digit_cnt, 2);
      press(KEY_STAR);
      check("t5_cleared", digit_cnt, 0);
      send_code(32'h1234, 4);
      check("t5_unlocked", unlocked, 1);
      check("t5_ok", ok_pulse, 1);

      // Program 9876 while open
      tick(KEY_STAR);
      check("t4_program", state, 3);
      tick(KEY_NONE);
      press(4'd9); press(4'd8); press(4'd7); press(4'd6);
      check("t4_cnt", digit_cnt, 4);
      tick(KEY_HASH);
      check("t4_ok", ok_pulse, 1);
      check("t4_open", state, 2);
      tick(KEY_NONE);
      tick(KEY_HASH);
      check("t4_relock", state, 0);
      check("t4_relock_unl", unlocked, 0);
      tick(KEY_NONE);
      send_code(32'h1234, 4);
      check("t4_old_err", err_pulse, 1);
      check("t4_old_unl", unlocked, 0);
      send_code(32'h9876, 4);
      check("t4_new_unl", unlocked, 1);
      check("t4_new_ok", ok_pulse, 1);

      // Asynchronous reset while open restores the default code
      #2;
      rst = 1'b1;
      #1;
      check("t6_async_unl", unlocked, 0);
      check("t6_async_state", state, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      send_code(32'h1234, 4);
      check("t6_default_unl", unlocked, 1);

      // Random traffic
      for (int it = 0; it < 8000; it++) begin
         r = int'($urandom_range(0, 999));
         if (r < 3) begin
            repeat ($urandom_range(995, 1005)) tick(KEY_NONE);
         end else if (r < 60) begin
            d = '0;
            for (int i = 0; i < CL; i++) d = (d << 4) | 32'(m_code[i]);
            send_code(d, CL);
         end else if (r < 550) begin
            tick(KEY_NONE);
         end else begin
            tick(4'($urandom_range(0, 15)));
         end
      end
      tick(KEY_NONE);

      chk_en = 1'b0;
      summary();
      $finish;
   end

endmodule
